// File: rtl/dnn_pkg.sv
// Shared constants, types and helpers for the inference engine and its result reader.
package dnn_pkg;

  localparam int DATA_WIDTH  = 14;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_WIDTH   = 4;

  typedef logic signed [DATA_WIDTH-1:0] score_t;
  typedef logic [IDX_WIDTH-1:0]         class_idx_t;
  typedef logic [DATA_WIDTH:0]          margin_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } reader_state_e;

  // Most-negative representable score, used to seed the runner-up tracker.
  function automatic score_t score_min();
    return {1'b1, {(DATA_WIDTH-1){1'b0}}};
  endfunction

  // Winner minus runner-up, widened by one bit so the full signed range fits.
  function automatic margin_t calc_margin(input score_t best, input score_t second);
    margin_t wide_best;
    margin_t wide_second;
    wide_best   = {best[DATA_WIDTH-1], best};
    wide_second = {second[DATA_WIDTH-1], second};
    return wide_best - wide_second;
  endfunction

endpackage

// File: rtl/dnn_result_reader_if.sv
// Result-port and classification-output bundle between the reader and its neighbours.
interface dnn_result_reader_if;
  import dnn_pkg::*;

  logic       start;
  class_idx_t out_idx;
  score_t     out;
  logic       busy;
  logic       result_valid;
  class_idx_t class_idx;
  score_t     class_score;
  margin_t    margin;

  modport slave (
    input  start, out,
    output out_idx, busy, result_valid, class_idx, class_score, margin
  );

  modport master (
    output start, out,
    input  out_idx, busy, result_valid, class_idx, class_score, margin
  );
endinterface

// File: rtl/dnn_top2_tracker.sv
// Next-state computation for the running best / second-best score pair.
module dnn_top2_tracker
  import dnn_pkg::*;
(
  input  score_t     score,
  input  class_idx_t idx,
  input  logic       first,
  input  score_t     best,
  input  score_t     second,
  input  class_idx_t best_idx,
  output score_t     best_nxt,
  output score_t     second_nxt,
  output class_idx_t best_idx_nxt
);

  // Strict comparison keeps the lower index on ties; a tie still lifts second to best.
  always_comb begin
    best_nxt     = best;
    second_nxt   = second;
    best_idx_nxt = best_idx;
    if (first) begin
      best_nxt     = score;
      second_nxt   = score_min();
      best_idx_nxt = {IDX_WIDTH{1'b0}};
    end else if (score > best) begin
      best_nxt     = score;
      second_nxt   = best;
      best_idx_nxt = idx;
    end else if (score > second) begin
      second_nxt   = score;
    end else begin
      second_nxt   = second;
    end
  end

endmodule

// File: rtl/dnn_result_reader.sv
// Scans the engine's indexed result port and registers argmax, winning score and margin.
module dnn_result_reader
  import dnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  dnn_result_reader_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SCAN = SCAN;
  localparam logic [1:0] ST_DONE = DONE;
  localparam class_idx_t LAST_IDX = class_idx_t'(NUM_CLASSES - 1);

  logic [1:0] state_r;
  class_idx_t idx_r;
  logic       busy_r;
  logic       valid_r;
  score_t     best_r;
  score_t     second_r;
  class_idx_t best_idx_r;
  class_idx_t class_idx_r;
  score_t     class_score_r;
  margin_t    margin_r;

  score_t     best_nxt_s;
  score_t     second_nxt_s;
  class_idx_t best_idx_nxt_s;
  logic       first_s;

  assign first_s = (idx_r == {IDX_WIDTH{1'b0}});

  dnn_top2_tracker u_tracker (
    .score        (bus.out),
    .idx          (idx_r),
    .first        (first_s),
    .best         (best_r),
    .second       (second_r),
    .best_idx     (best_idx_r),
    .best_nxt     (best_nxt_s),
    .second_nxt   (second_nxt_s),
    .best_idx_nxt (best_idx_nxt_s)
  );

  // Scan sequencer: walks out_idx across all classes, then publishes one result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      idx_r         <= {IDX_WIDTH{1'b0}};
      busy_r        <= 1'b0;
      valid_r       <= 1'b0;
      best_r        <= {DATA_WIDTH{1'b0}};
      second_r      <= {DATA_WIDTH{1'b0}};
      best_idx_r    <= {IDX_WIDTH{1'b0}};
      class_idx_r   <= {IDX_WIDTH{1'b0}};
      class_score_r <= {DATA_WIDTH{1'b0}};
      margin_r      <= {(DATA_WIDTH+1){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r <= ST_SCAN;
            idx_r   <= {IDX_WIDTH{1'b0}};
            busy_r  <= 1'b1;
            valid_r <= 1'b0;
          end
        end
        ST_SCAN: begin
          best_r     <= best_nxt_s;
          second_r   <= second_nxt_s;
          best_idx_r <= best_idx_nxt_s;
          if (idx_r == LAST_IDX) begin
            idx_r   <= {IDX_WIDTH{1'b0}};
            state_r <= ST_DONE;
          end else begin
            idx_r   <= idx_r + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          class_idx_r   <= best_idx_r;
          class_score_r <= best_r;
          margin_r      <= calc_margin(best_r, second_r);
          valid_r       <= 1'b1;
          busy_r        <= 1'b0;
          state_r       <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= {IDX_WIDTH{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_idx      = idx_r;
  assign bus.busy         = busy_r;
  assign bus.result_valid = valid_r;
  assign bus.class_idx    = class_idx_r;
  assign bus.class_score  = class_score_r;
  assign bus.margin       = margin_r;

endmodule

// File: tb/tb_dnn_result_reader.sv
// Scoreboard bench for dnn_result_reader: directed score tables, monitor on result_valid.
module tb_dnn_result_reader;
  import dnn_pkg::*;

  typedef struct {
    int idx;
    int score;
    int margin;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst;
  score_t scores [NUM_CLASSES];
  int     vec    [NUM_CLASSES];
  exp_t   q [$];
  int     total = 0;
  int     bad   = 0;
  string  tag   = "reset";

  always #5 clk = ~clk;

  dnn_result_reader_if intf ();

  dnn_result_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  // Engine model: combinational score lookup for the selected index.
  assign intf.out = (intf.out_idx < 4'd10) ? scores[intf.out_idx] : 14'sd0;

  task automatic check(input string nm, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s.%s: got %0d expected %0d", tag, nm, act, exp_v);
    end
  endtask

  task automatic load();
    for (int i = 0; i < NUM_CLASSES; i++) scores[i] = score_t'(vec[i]);
  endtask

  task automatic check_zero();
    check("out_idx",      int'(intf.out_idx), 0);
    check("busy",         int'(intf.busy), 0);
    check("result_valid", int'(intf.result_valid), 0);
    check("class_idx0",   int'(intf.class_idx), 0);
    check("class_score0", int'(intf.class_score), 0);
    check("margin0",      int'(intf.margin), 0);
  endtask

  // One full scan with per-cycle checks of busy, result_valid and out_idx.
  task automatic do_scan(input bit repulse, input int ei, input int es, input int em);
    exp_t e;
    e.idx = ei; e.score = es; e.margin = em;
    q.push_back(e);
    @(negedge clk);
    intf.start = 1'b1;
    @(posedge clk);
    #1;
    intf.start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
        intf.start = repulse && (c == 3 || c == 7);
      end
      check($sformatf("busy_c%0d", c), int'(intf.busy), (c <= 11) ? 1 : 0);
      check($sformatf("valid_c%0d", c), int'(intf.result_valid), (c >= 12) ? 1 : 0);
      check($sformatf("out_idx_c%0d", c), int'(intf.out_idx), (c <= 10) ? c - 1 : 0);
    end
    intf.start = 1'b0;
  endtask

  // Monitor: on each rising result_valid, compare against the oldest expected result.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (intf.result_valid && !prev) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL %s.unexpected_result: got class %0d expected no result", tag, intf.class_idx);
        end else begin
          e = q.pop_front();
          check("class_idx",   int'(intf.class_idx), e.idx);
          check("class_score", int'(intf.class_score), e.score);
          check("margin",      int'(intf.margin), e.margin);
        end
      end
      prev = intf.result_valid;
    end
  end

  initial begin
    rst        = 1'b1;
    intf.start = 1'b0;
    for (int i = 0; i < NUM_CLASSES; i++) scores[i] = 14'sd0;
    repeat (2) @(posedge clk);
    #1;
    check_zero();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_zero();

    tag = "mixed";
    vec = '{-100, -50, 0, 25, 8191, 12, -8192, 3, 4, 5};
    load();
    do_scan(1'b0, 4, 8191, 8166);

    tag = "all_equal";
    vec = '{300, 300, 300, 300, 300, 300, 300, 300, 300, 300};
    load();
    do_scan(1'b0, 0, 300, 0);

    tag = "last_wins";
    vec = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 500};
    load();
    do_scan(1'b0, 9, 500, 400);

    tag = "extreme";
    vec = '{-8192, -8192, 8191, -8192, -8192, -8192, -8192, -8192, -8192, -8192};
    load();
    do_scan(1'b0, 2, 8191, 16383);

    tag = "repulse";
    vec = '{10, 20, 30, 40, 50, 60, 70, 80, 90, -1};
    load();
    do_scan(1'b1, 8, 90, 10);

    tag = "mid_rst";
    @(negedge clk);
    intf.start = 1'b1;
    @(posedge clk);
    #1;
    intf.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    tag = "after_rst";
    vec = '{-5, -6, -7, -1, -2, -3, -4, -8, -9, -10};
    load();
    do_scan(1'b0, 3, -1, 1);

    repeat (3) @(posedge clk);
    #1;
    tag = "final";
    check("pending_results", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dnn_result_reader.md
Name: dnn_result_reader

Overview:
Consumer side of the inference engine's indexed result port. After the engine signals done, this block drives the output-select index 0..NUM_CLASSES-1, samples each signed fixed-point score, and computes the winning class (argmax), its score, and the margin over the runner-up. It sits between the sigmoid inference top level and the board-level display/UART logic. It gives downstream logic a single registered classification result in place of ten scores.

Parameters:
DATA_WIDTH, 14, width of a signed fixed-point class score (matches engine output)
NUM_CLASSES, 10, number of output neurons scanned
IDX_WIDTH, 4, width of the class index / select bus

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to scan results; tie to engine done edge
out_idx  output  IDX_WIDTH  select index driven to the engine's result port
out  input  DATA_WIDTH  signed score returned combinationally for out_idx
busy  output  1  high while scanning
result_valid  output  1  high from scan completion until next accepted start or rst
class_idx  output  IDX_WIDTH  winning class index
class_score  output  DATA_WIDTH  signed score of the winner
margin  output  DATA_WIDTH+1  unsigned difference, winner score minus runner-up score

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- Reset values: all outputs 0. The FSM is in IDLE.
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - start=1 moves to SCAN, sets out_idx<=0 and busy<=1, and clears result_valid.
- SCAN:
  - out_idx is registered. out is combinational from it, so out is sampled in the same cycle out_idx holds index i.
  - i==0: best<=out, best_idx<=0, second<=most-negative value (-2^(DATA_WIDTH-1)).
  - i>0, out>best (signed, strict): second<=best, best<=out, best_idx<=i.
  - i>0, otherwise, out>second: second<=out.
  - Ties keep the lower index as winner. A tie sets second equal to best, giving margin 0.
  - i==NUM_CLASSES-1: after the update, go to DONE. out_idx returns to 0.
  - Otherwise out_idx<=i+1.
- DONE (one cycle):
  - Register class_idx, class_score=best, and margin=best-second, computed in DATA_WIDTH+1 signed arithmetic and always >=0.
  - Set result_valid<=1 and busy<=0, then return to IDLE.
- Latency: start sampled in cycle 0. SCAN covers cycles 1..NUM_CLASSES. result_valid is high from cycle NUM_CLASSES+2 (cycle 12 for the defaults).
- start while in SCAN or DONE is ignored; no queueing.
- start in IDLE while result_valid=1 begins a new scan. result_valid drops the cycle after start is accepted.
- class_idx, class_score and margin hold their values until the next DONE or rst.
- rst mid-scan returns to IDLE immediately with all outputs 0. No partial result is ever presented.
- out_idx never exceeds NUM_CLASSES-1.

Decomposition:
- Shared package dnn_pkg holds:
  - DATA_WIDTH, NUM_CLASSES and IDX_WIDTH constants, shared with the inference top level.
  - typedef score_t: signed [DATA_WIDTH-1:0].
  - typedef class_idx_t.
  - enum reader_state_e {IDLE, SCAN, DONE}.
- One sub-module is natural: dnn_top2_tracker, a combinational/registered best/second-best update given (score, idx, first).

Test Plan:
- Model returns scores [-100,-50,0,25,8191,12,-8192,3,4,5]; pulse start -> result_valid at cycle 12, class_idx=4, class_score=8191, margin=8166.
- Scores all equal to 300 -> class_idx=0, class_score=300, margin=0.
- Winner at index 9 (9 -> 500, others -> 100) -> class_idx=9, margin=400. Runner-up at index 0 is correctly tracked before replacement.
- Extreme range: index 2 = 8191, index 5 = -8192, all others = -8192 -> margin=16383 with no overflow (15-bit result).
- start re-pulsed at cycles 3 and 7 during SCAN -> ignored. The single result appears at cycle 12. busy stays high for cycles 1-11.
- rst asserted asynchronously at cycle 5 mid-scan -> all outputs 0 immediately. A new start after release produces a correct result 12 cycles later.
